// File: rtl/rf_access_arbiter.sv
// rtl/rf_access_arbiter.sv - round-robin two-requester access controller for a small register file
module rf_access_arbiter #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rf_read_enable,
    output logic                  rf_write_enable,
    output logic [ADDR_W-1:0]     rf_r_address,
    output logic [ADDR_W-1:0]     rf_w_address,
    output logic [DATA_W-1:0]     rf_write_data,
    input  logic [DATA_W-1:0]     rf_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q;
    logic                last_q;
    logic                win_q;
    logic [1:0]          gnt_q;
    logic [1:0]          rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                re_q;
    logic                we_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                win_d;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        win_d     = (req == 2'b11) ? ~last_q : req[1];
        sel_we    = win_d ? we[1] : we[0];
        sel_addr  = win_d ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        sel_wdata = win_d ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            win_q    <= 1'b0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            // Pulses and file controls default low; only the ACCESS entry raises them.
            gnt_q    <= '0;
            rvalid_q <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q <= ACCESS;
                        last_q  <= win_d;
                        win_q   <= win_d;
                        gnt_q   <= {win_d, ~win_d};
                        if (sel_we) begin
                            we_q    <= 1'b1;
                            waddr_q <= sel_addr;
                            wdata_q <= sel_wdata;
                        end else begin
                            re_q    <= 1'b1;
                            raddr_q <= sel_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (re_q) begin
                        rdata_q  <= rf_read_data;
                        rvalid_q <= {win_q, ~win_q};
                        state_q  <= RESP;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt             = gnt_q;
    assign rvalid          = rvalid_q;
    assign rdata           = rdata_q;
    assign rf_read_enable  = re_q;
    assign rf_write_enable = we_q;
    assign rf_r_address    = raddr_q;
    assign rf_w_address    = waddr_q;
    assign rf_write_data   = wdata_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// tb/tb_rf_access_arbiter.sv - directed and constrained-random checks of rf_access_arbiter
module tb_rf_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic        rf_read_enable;
    logic        rf_write_enable;
    logic [1:0]  rf_r_address;
    logic [1:0]  rf_w_address;
    logic [7:0]  rf_write_data;
    logic [7:0]  rf_read_data;

    logic [7:0]  mem [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0]  smem [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_access_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req),
        .we              (we),
        .addr            (addr),
        .wdata           (wdata),
        .gnt             (gnt),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .rf_read_enable  (rf_read_enable),
        .rf_write_enable (rf_write_enable),
        .rf_r_address    (rf_r_address),
        .rf_w_address    (rf_w_address),
        .rf_write_data   (rf_write_data),
        .rf_read_data    (rf_read_data)
    );

    assign rf_read_data = rf_read_enable ? mem[rf_r_address] : 8'h00;

    always @(posedge clk) begin
        if (rf_write_enable) mem[rf_w_address] <= rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic       pend [2];
    logic       pwe [2];
    logic [1:0] paddr [2];
    logic [7:0] pdata [2];
    logic [1:0] exp_rv;
    logic [7:0] exp_rd;

    initial begin
        rst_n = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
        step(); step();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_en", {rf_read_enable, rf_write_enable}, 2'b00);
        chk("rst_addr", {rf_r_address, rf_w_address, rf_write_data}, 12'h000);
        rst_n = 1'b1;
        step();

        // single write from requester 0
        req = 2'b01; we = 2'b01; addr = {2'd0, 2'd2}; wdata = {8'h00, 8'hA5};
        step();
        chk("wr_gnt", gnt, 2'b01);
        chk("wr_en", {rf_read_enable, rf_write_enable}, 2'b01);
        chk("wr_addr", rf_w_address, 2'd2);
        chk("wr_data", rf_write_data, 8'hA5);
        req = 2'b00;
        step();
        chk("wr_idle_gnt", gnt, 2'b00);
        chk("wr_idle_en", {rf_read_enable, rf_write_enable}, 2'b00);
        chk("wr_idle_addr", {rf_r_address, rf_w_address, rf_write_data}, 12'h000);
        chk("wr_mem", mem[2], 8'hA5);

        // read-back from requester 1
        req = 2'b10; we = 2'b00; addr = {2'd2, 2'd0}; wdata = '0;
        step();
        chk("rd_gnt", gnt, 2'b10);
        chk("rd_en", {rf_read_enable, rf_write_enable}, 2'b10);
        chk("rd_addr", rf_r_address, 2'd2);
        req = 2'b00;
        step();
        chk("rd_rvalid", rvalid, 2'b10);
        chk("rd_rdata", rdata, 8'hA5);
        chk("rd_resp_en", {rf_read_enable, rf_write_enable}, 2'b00);
        step();
        chk("rd_rvalid_end", rvalid, 2'b00);
        chk("rd_rdata_hold", rdata, 8'hA5);

        // tie after reset: alternating grants
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        req = 2'b11; we = 2'b00; addr = {2'd1, 2'd2};
        for (int i = 0; i < 6; i++) begin
            step();
            chk("tie_gnt", gnt, (i % 2) ? 2'b10 : 2'b01);
            step();
            chk("tie_rvalid", rvalid, (i % 2) ? 2'b10 : 2'b01);
            chk("tie_rdata", rdata, (i % 2) ? 8'h00 : 8'hA5);
            step();
        end
        req = 2'b00;
        step(); step(); step();

        // random traffic against a shadow register file
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; pwe[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
        end
        exp_rv = 2'b00; exp_rd = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            chk("rnd_excl", {31'd0, rf_read_enable & rf_write_enable}, 32'd0);
            chk("rnd_gnt_hot", {31'd0, gnt == 2'b11}, 32'd0);
            chk("rnd_rv_hot", {31'd0, rvalid == 2'b11}, 32'd0);
            chk("rnd_rvalid", rvalid, exp_rv);
            if (exp_rv != 2'b00) chk("rnd_rdata", rdata, exp_rd);
            exp_rv = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    chk("rnd_gnt_pend", {31'd0, pend[i]}, 32'd1);
                    if (pwe[i]) begin
                        chk("rnd_wen", {rf_read_enable, rf_write_enable}, 2'b01);
                        chk("rnd_waddr", rf_w_address, paddr[i]);
                        chk("rnd_wdata", rf_write_data, pdata[i]);
                        smem[paddr[i]] = pdata[i];
                    end else begin
                        chk("rnd_ren", {rf_read_enable, rf_write_enable}, 2'b10);
                        chk("rnd_raddr", rf_r_address, paddr[i]);
                        exp_rv = (i == 1) ? 2'b10 : 2'b01;
                        exp_rd = smem[paddr[i]];
                    end
                    pend[i] = 1'b0;
                end else if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i]  = 1'b1;
                    pwe[i]   = 1'($urandom_range(0, 1));
                    paddr[i] = 2'($urandom_range(0, 3));
                    pdata[i] = 8'($urandom_range(0, 255));
                end
            end
            req   = {pend[1], pend[0]};
            we    = {pwe[1], pwe[0]};
            addr  = {paddr[1], paddr[0]};
            wdata = {pdata[1], pdata[0]};
            step();
        end
        req = 2'b00;
        step(); step(); step(); step();

        // reset asserted during a read ACCESS
        req = 2'b01; we = 2'b00; addr = {2'd0, 2'd2};
        step();
        chk("mid_gnt_pre", gnt, 2'b01);
        chk("mid_ren_pre", rf_read_enable, 1'b1);
        req = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_en", {rf_read_enable, rf_write_enable}, 2'b00);
        chk("mid_gnt", gnt, 2'b00);
        chk("mid_rdata", rdata, 8'h00);
        chk("mid_raddr", rf_r_address, 2'd0);
        step();
        chk("mid_no_rvalid", rvalid, 2'b00);
        rst_n = 1'b1;
        step();
        chk("mid_no_rvalid2", rvalid, 2'b00);
        req = 2'b11; we = 2'b00; addr = {2'd1, 2'd2};
        step();
        chk("mid_tie_gnt", gnt, 2'b01);
        req = 2'b00;
        step(); step();

        // request cancelled before the IDLE sampling edge
        req = 2'b10; we = 2'b00; addr = {2'd1, 2'd0};
        step();
        chk("cx_gnt", gnt, 2'b10);
        req = 2'b00;
        step();
        chk("cx_rvalid", rvalid, 2'b10);
        req = 2'b01;
        step();
        req = 2'b00;
        chk("cx_idle_gnt", gnt, 2'b00);
        step();
        chk("cx_no_gnt", gnt, 2'b00);
        chk("cx_no_en", {rf_read_enable, rf_write_enable}, 2'b00);
        step();
        chk("cx_still_idle", gnt, 2'b00);
        chk("cx_no_rvalid", rvalid, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
